// File: rtl/tone_contour_synth.sv
// rtl/tone_contour_synth.sv - phase-accumulator tone synthesiser following a 4-segment pitch contour
// Define TONE_SYNTH_TRIANGLE_EN for a triangle waveform; the default waveform is a sawtooth.
module tone_contour_synth #(
  parameter int unsigned CLKS_PER_SAMPLE = 2268,
  parameter int unsigned SEG_SAMPLES     = 1024,
  parameter logic [31:0] BASE_INC        = 32'h0092_0000,
  parameter logic [31:0] DELTA_INC       = 32'h0020_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [2:0]  tone_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        done_out,
  output logic        error_out,
  output logic        busy_out
);

  localparam int unsigned DIV_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam int unsigned CNT_W = (SEG_SAMPLES > 1) ? $clog2(SEG_SAMPLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_SAMPLE - 1);
  localparam logic [CNT_W-1:0] SCNT_LAST = CNT_W'(SEG_SAMPLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [2:0]       code_q, code_d;
  logic [31:0]      phase_q, phase_d;
  logic [1:0]       seg_q, seg_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      sample_q, sample_d;
  logic             sv_q, sv_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [31:0] inc;
  logic [15:0] wave;
  logic        code_ok;
  logic        first_cycle;

  assign code_ok = (code_q == 3'b000) || (code_q == 3'b001) ||
                   (code_q == 3'b010) || (code_q == 3'b100);

  // Unsupported codes fall through to the flat contour.
  always_comb begin
    inc = BASE_INC;
    case (code_q)
      3'b001: begin
        case (seg_q)
          2'd0:    inc = BASE_INC;
          2'd1:    inc = BASE_INC + DELTA_INC;
          2'd2:    inc = BASE_INC + (DELTA_INC << 1);
          default: inc = BASE_INC + DELTA_INC + (DELTA_INC << 1);
        endcase
      end
      3'b010: begin
        case (seg_q)
          2'd0:    inc = BASE_INC + DELTA_INC + (DELTA_INC << 1);
          2'd1:    inc = BASE_INC + (DELTA_INC << 1);
          2'd2:    inc = BASE_INC + DELTA_INC;
          default: inc = BASE_INC;
        endcase
      end
      3'b100: begin
        if (seg_q == 2'd1 || seg_q == 2'd2) inc = BASE_INC - DELTA_INC;
        else                                inc = BASE_INC;
      end
      default: inc = BASE_INC;
    endcase
  end

`ifdef TONE_SYNTH_TRIANGLE_EN
  logic [15:0] tri_val;
  always_comb begin
    tri_val = phase_q[31] ? ~phase_q[30:15] : phase_q[30:15];
    wave    = tri_val ^ 16'h8000;
  end
`else
  always_comb begin
    wave = {~phase_q[31], phase_q[30:16]};
  end
`endif

  // Only the cycle right after accept has divider, segment and sample count all zero.
  assign first_cycle = (div_q == '0) && (seg_q == 2'd0) && (scnt_q == '0);

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    phase_d  = phase_q;
    seg_d    = seg_q;
    scnt_d   = scnt_q;
    div_d    = div_q;
    sample_d = sample_q;
    sv_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          state_d = S_PLAY;
          code_d  = tone_in;
          phase_d = '0;
          seg_d   = '0;
          scnt_d  = '0;
          div_d   = '0;
        end
      end
      S_PLAY: begin
        err_d = first_cycle && !code_ok;
        if (div_q == DIV_LAST) begin
          div_d    = '0;
          sample_d = wave;
          sv_d     = 1'b1;
          phase_d  = phase_q + inc;
          if (scnt_q == SCNT_LAST) begin
            scnt_d = '0;
            if (seg_q == 2'd3) state_d = S_DONE;
            else               seg_d   = seg_q + 2'd1;
          end else begin
            scnt_d = scnt_q + CNT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        // First DONE cycle raises done_out; ready returns the cycle after the pulse.
        if (!done_q) done_d  = 1'b1;
        else         state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      code_q   <= '0;
      phase_q  <= '0;
      seg_q    <= '0;
      scnt_q   <= '0;
      div_q    <= '0;
      sample_q <= '0;
      sv_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      phase_q  <= phase_d;
      seg_q    <= seg_d;
      scnt_q   <= scnt_d;
      div_q    <= div_d;
      sample_q <= sample_d;
      sv_q     <= sv_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign ready_out    = (state_q == S_IDLE);
  assign busy_out     = (state_q != S_IDLE);
  assign sample_out   = sample_q;
  assign sample_valid = sv_q;
  assign done_out     = done_q;
  assign error_out    = err_q;

endmodule

// File: tb/tb_tone_contour_synth.sv
// tb/tb_tone_contour_synth.sv - scoreboard bench for tone_contour_synth (small test parameters)
// Honours TONE_SYNTH_TRIANGLE_EN in its reference waveform.
module tb_tone_contour_synth;

  localparam logic [31:0] B = 32'h1000_0000;
  localparam logic [31:0] D = 32'h0800_0000;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [2:0]  tone_in;
  logic        valid_in;
  logic        ready_out;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        done_out;
  logic        error_out;
  logic        busy_out;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got[16];

  tone_contour_synth #(
    .CLKS_PER_SAMPLE(2),
    .SEG_SAMPLES(4),
    .BASE_INC(B),
    .DELTA_INC(D)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .tone_in(tone_in),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .sample_out(sample_out),
    .sample_valid(sample_valid),
    .done_out(done_out),
    .error_out(error_out),
    .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [15:0] ref_wave(input logic [31:0] p);
    logic [15:0] t;
`ifdef TONE_SYNTH_TRIANGLE_EN
    t = p[31] ? ~p[30:15] : p[30:15];
    return t ^ 16'h8000;
`else
    t = {~p[31], p[30:16]};
    return t;
`endif
  endfunction

  function automatic logic [31:0] ref_inc(input logic [2:0] c, input int s);
    case (c)
      3'b001:  return B + D * 32'(s);
      3'b010:  return B + D * 32'(3 - s);
      3'b100:  return (s == 1 || s == 2) ? B - D : B;
      default: return B;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input logic [2:0] code);
    logic [31:0] ph;
    ph = '0;
    for (int n = 0; n < 16; n++) begin
      exp_q.push_back(ref_wave(ph));
      ph = ph + ref_inc(code, n / 4);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ready_out, 1);
    check({tag, "_sample"}, sample_out, 0);
    check({tag, "_svalid"}, sample_valid, 0);
    check({tag, "_done"}, done_out, 0);
    check({tag, "_error"}, error_out, 0);
    check({tag, "_busy"}, busy_out, 0);
  endtask

  // Accepts one code and follows the run through T+34; optionally keeps valid_in high with another code.
  task automatic play(input logic [2:0] code, input logic hold, input logic [2:0] hold_code, input string tag);
    int nstrobe, first_done, ndone, nerr;
    logic bad;
    logic [15:0] e;
    push_expected(code);
    bad = !(code inside {3'b000, 3'b001, 3'b010, 3'b100});
    check({tag, "_ready_before"}, ready_out, 1);
    tone_in  = code;
    valid_in = 1'b1;
    @(posedge clk_in); #1;
    if (hold) tone_in = hold_code;
    else      valid_in = 1'b0;
    check({tag, "_busy_after_accept"}, busy_out, 1);
    nstrobe = 0; first_done = -1; ndone = 0; nerr = 0;
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk_in); #1;
      if (k == 1) check({tag, "_error_t1"}, error_out, bad);
      if (error_out) nerr++;
      if (done_out) begin
        ndone++;
        if (first_done < 0) first_done = k;
      end
      if (sample_valid) begin
        nstrobe++;
        check({tag, "_strobe_time"}, k, 2 * nstrobe);
        if (exp_q.size() == 0) check({tag, "_sb_underflow"}, 1, 0);
        else begin
          e = exp_q.pop_front();
          check({tag, "_sample"}, sample_out, e);
        end
        if (nstrobe <= 16) got[nstrobe-1] = sample_out;
      end
      if (k == 33) check({tag, "_ready_low_in_done"}, ready_out, 0);
    end
    check({tag, "_strobe_count"}, nstrobe, 16);
    check({tag, "_done_time"}, first_done, 33);
    check({tag, "_done_count"}, ndone, 1);
    check({tag, "_error_count"}, nerr, bad ? 1 : 0);
    check({tag, "_ready_t34"}, ready_out, 1);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int ndone, nsv;
    rst_in   = 1'b1;
    valid_in = 1'b0;
    tone_in  = 3'b000;
    repeat (3) @(posedge clk_in);
    #1;
    check_reset_outputs("por");
    rst_in = 1'b0;

    play(3'b000, 1'b0, 3'b000, "flat");
    check("flat_first", got[0], 16'h8000);
`ifdef TONE_SYNTH_TRIANGLE_EN
    check("flat_9th", got[8], 16'h7FFF);
`else
    check("flat_9th", got[8], 16'h0000);
    check("flat_last", got[15], 16'h7000);
`endif

    play(3'b001, 1'b0, 3'b000, "rising");
    check("rising_12th", got[11], 16'h8000);

    play(3'b011, 1'b0, 3'b000, "code011");

    play(3'b000, 1'b1, 3'b010, "flat_busy_valid");
    play(3'b010, 1'b0, 3'b000, "falling");

    play(3'b100, 1'b0, 3'b000, "dipping");

    tone_in  = 3'b000;
    valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    repeat (8) @(posedge clk_in);
    #1;
    check("pre_reset_busy", busy_out, 1);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    check_reset_outputs("midplay_reset");
    rst_in = 1'b0;
    ndone = 0; nsv = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk_in); #1;
      if (done_out) ndone++;
      if (sample_valid) nsv++;
    end
    check("after_reset_no_done", ndone, 0);
    check("after_reset_no_strobe", nsv, 0);
    play(3'b000, 1'b0, 3'b000, "after_reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
